// File: rtl/clk_div_prog.sv
// Programmable even-ratio, glitch-free clock divider with rise/fall strobes and a rising-edge phase count.
// Latency: every output is a flop; a pending ratio is applied on the next enabled falling edge of new_clk.
// Backpressure: none; en=0 freezes the divider, and ratio loads are accepted whether or not en is high.
module clk_div_prog #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   output logic             div_ack,
   output logic             div_err,
   output logic             new_clk,
   output logic             rise_tick,
   output logic             fall_tick,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] cur_div
);

   localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE_W     = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(2);

   logic [CNT_W-1:0] cnt;        // enabled edges since the last toggle
   logic [CNT_W-1:0] half_last;  // count value on which new_clk toggles
   logic [CNT_W-1:0] div_rnd;    // requested ratio rounded down to even
   logic [CNT_W-1:0] pend_div;   // ratio waiting for the next period boundary
   logic             pend_vld;
   logic             toggle;     // new_clk flips on this edge
   logic             boundary;   // enabled 1->0 toggle: the only point a ratio may change
   logic             load_ok;
   logic             load_bad;

   // Decode toggle point, period boundary and load legality from the current state.
   always_comb begin
      half_last = (cur_div >> 1) - ONE_W;
      toggle    = en && (cnt == half_last);
      boundary  = toggle && new_clk;
      div_rnd   = div_in & ~ONE_W;
      load_ok   = div_load && (div_rnd >= MIN_DIV_W);
      load_bad  = div_load && (div_rnd < MIN_DIV_W);
   end

   // Half-period counter, divided clock flop, edge strobes and phase count.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt       <= '0;
         new_clk   <= 1'b0;
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
         phase     <= 2'd0;
      end else begin
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
         if (en) begin
            if (toggle) begin
               cnt     <= '0;
               new_clk <= ~new_clk;
               if (new_clk) begin
                  fall_tick <= 1'b1;
               end else begin
                  rise_tick <= 1'b1;
                  phase     <= phase + 2'd1;
               end
            end else begin
               cnt <= cnt + ONE_W;
            end
         end
      end
   end

   // Active ratio: swapped in only at a period boundary so the following low half already uses it.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cur_div <= DEF_DIV_W;
         div_ack <= 1'b0;
      end else begin
         div_ack <= 1'b0;
         if (boundary && pend_vld) begin
            cur_div <= pend_div;
            div_ack <= 1'b1;
         end
      end
   end

   // Pending ratio: last legal load wins; a load on a boundary edge waits for the next boundary.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pend_div <= DEF_DIV_W;
         pend_vld <= 1'b0;
      end else begin
         if (load_ok) begin
            pend_div <= div_rnd;
            pend_vld <= 1'b1;
         end else if (boundary) begin
            pend_vld <= 1'b0;
         end
      end
   end

   // Rejected-load strobe for ratios that round below 2.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         div_err <= 1'b0;
      end else begin
         div_err <= load_bad;
      end
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized and directed bench for clk_div_prog against an edge-scheduling reference model.
// Latency: model state is compared with the DUT on every falling clk edge.
// Backpressure: not applicable; stimulus drives en, loads and occasional async resets.
module tb_clk_div_prog;

   localparam int CNT_W   = 8;
   localparam int DEF_DIV = 4;

   logic             clk      = 1'b0;
   logic             clr      = 1'b0;
   logic             en       = 1'b0;
   logic [CNT_W-1:0] div_in   = '0;
   logic             div_load = 1'b0;
   logic             div_ack;
   logic             div_err;
   logic             new_clk;
   logic             rise_tick;
   logic             fall_tick;
   logic [1:0]       phase;
   logic [CNT_W-1:0] cur_div;

   int checks = 0;
   int errors = 0;

   clk_div_prog #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
      .clk       (clk),
      .clr       (clr),
      .en        (en),
      .div_in    (div_in),
      .div_load  (div_load),
      .div_ack   (div_ack),
      .div_err   (div_err),
      .new_clk   (new_clk),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick),
      .phase     (phase),
      .cur_div   (cur_div)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: schedules each toggle as an absolute enabled-edge index.
   int m_edges, m_next, m_div, m_pend, m_phase, m_r;
   bit m_clk, m_pv, m_rise, m_fall, m_ack, m_err;

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         m_edges = 0;
         m_div   = DEF_DIV;
         m_next  = DEF_DIV / 2;
         m_pend  = 0;
         m_pv    = 0;
         m_phase = 0;
         m_clk   = 0;
         m_rise  = 0;
         m_fall  = 0;
         m_ack   = 0;
         m_err   = 0;
      end else begin
         m_rise = 0;
         m_fall = 0;
         m_ack  = 0;
         m_err  = 0;
         if (en) begin
            m_edges++;
            if (m_edges == m_next) begin
               if (m_clk) begin
                  m_clk  = 0;
                  m_fall = 1;
                  if (m_pv) begin
                     m_div = m_pend;
                     m_pv  = 0;
                     m_ack = 1;
                  end
               end else begin
                  m_clk   = 1;
                  m_rise  = 1;
                  m_phase = (m_phase + 1) % 4;
               end
               m_next = m_edges + m_div / 2;
            end
         end
         if (div_load) begin
            m_r = int'(div_in) & ~1;
            if (m_r < 2) begin
               m_err = 1;
            end else begin
               m_pend = m_r;
               m_pv   = 1;
            end
         end
      end
   end

   // Compare every output with the model away from the active edge.
   always @(negedge clk) begin
      chk("m_new_clk", new_clk, m_clk);
      chk("m_rise_tick", rise_tick, m_rise);
      chk("m_fall_tick", fall_tick, m_fall);
      chk("m_phase", phase, m_phase);
      chk("m_cur_div", cur_div, m_div);
      chk("m_div_ack", div_ack, m_ack);
      chk("m_div_err", div_err, m_err);
   end

   // Pulse reset between edges, check reset values, release with en=1 so the next edge is edge 1.
   task automatic do_reset();
      @(posedge clk);
      #1;
      en       = 1'b0;
      div_load = 1'b0;
      div_in   = '0;
      clr      = 1'b1;
      #1;
      chk("rst_new_clk", new_clk, 0);
      chk("rst_phase", phase, 0);
      chk("rst_cur_div", cur_div, DEF_DIV);
      chk("rst_ticks", {rise_tick, fall_tick, div_ack, div_err}, 0);
      #1;
      clr = 1'b0;
      en  = 1'b1;
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   int acks;

   initial begin
      #1 clr = 1'b1;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;

      // Default N=4 waveform, strobes and phase wrap.
      do_reset();
      for (int k = 1; k <= 14; k++) begin
         next_edge();
         chk("t1_new_clk", new_clk, (k / 2) % 2);
         chk("t1_rise", rise_tick, (k % 4) == 2);
         chk("t1_fall", fall_tick, (k % 4) == 0);
         chk("t1_phase", phase, ((k + 2) / 4) % 4);
      end

      // Load 8 captured in the high half; applied at the fall after edge 4.
      do_reset();
      repeat (2) next_edge();
      div_in   = 8'd8;
      div_load = 1'b1;
      next_edge();
      div_load = 1'b0;
      next_edge();
      chk("t2_new_clk_e4", new_clk, 0);
      chk("t2_ack_e4", div_ack, 1);
      chk("t2_cur_div", cur_div, 8);
      repeat (3) next_edge();
      chk("t2_new_clk_e7", new_clk, 0);
      next_edge();
      chk("t2_rise_e8", {new_clk, rise_tick}, 2'b11);
      repeat (4) next_edge();
      chk("t2_fall_e12", {new_clk, fall_tick}, 2'b01);

      // Odd ratio rounds down; ratio 1 is rejected.
      do_reset();
      div_in   = 8'd7;
      div_load = 1'b1;
      next_edge();
      div_load = 1'b0;
      repeat (3) next_edge();
      chk("t3_ack", div_ack, 1);
      chk("t3_cur_div6", cur_div, 6);
      div_in   = 8'd1;
      div_load = 1'b1;
      next_edge();
      div_load = 1'b0;
      chk("t3_err", div_err, 1);
      chk("t3_cur_div_hold", cur_div, 6);
      acks = 0;
      repeat (5) begin
         next_edge();
         acks += int'(div_ack);
      end
      chk("t3_no_ack", acks, 0);
      chk("t3_fall_e10", {new_clk, fall_tick}, 2'b01);

      // Back-to-back loads: last wins, exactly one ack.
      do_reset();
      div_in   = 8'd10;
      div_load = 1'b1;
      next_edge();
      div_in   = 8'd6;
      next_edge();
      div_load = 1'b0;
      acks = 0;
      next_edge();
      acks += int'(div_ack);
      next_edge();
      acks += int'(div_ack);
      chk("t4_cur_div", cur_div, 6);
      repeat (12) begin
         next_edge();
         acks += int'(div_ack);
      end
      chk("t4_one_ack", acks, 1);
      chk("t4_fall_e16", {new_clk, fall_tick}, 2'b01);

      // Enable low for 5 cycles in the high half.
      do_reset();
      repeat (2) next_edge();
      en = 1'b0;
      repeat (5) begin
         next_edge();
         chk("t5_hold_clk", new_clk, 1);
         chk("t5_no_ticks", {rise_tick, fall_tick}, 0);
         chk("t5_phase", phase, 1);
      end
      en = 1'b1;
      next_edge();
      chk("t5_still_high", new_clk, 1);
      next_edge();
      chk("t5_fall", {new_clk, fall_tick}, 2'b01);

      // Async reset while a ratio is pending and new_clk is high.
      do_reset();
      div_in   = 8'd8;
      div_load = 1'b1;
      next_edge();
      div_load = 1'b0;
      next_edge();
      chk("t6_pre_high", new_clk, 1);
      #2 clr = 1'b1;
      #1;
      chk("t6_clr_clk", new_clk, 0);
      chk("t6_clr_phase", phase, 0);
      chk("t6_clr_div", cur_div, 4);
      next_edge();
      clr = 1'b0;
      repeat (2) next_edge();
      chk("t6_rise_e2", {new_clk, rise_tick}, 2'b11);
      repeat (2) next_edge();
      chk("t6_fall_e4", {new_clk, div_ack}, 2'b00);
      chk("t6_div_kept", cur_div, 4);

      // Randomized run against the model.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         en       = ($urandom_range(0, 9) != 0);
         div_load = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) div_in = CNT_W'($urandom_range(0, 255));
         else                           div_in = CNT_W'($urandom_range(0, 12));
         if ($urandom_range(0, 999) == 0) begin
            clr = 1'b1;
            #2 clr = 1'b0;
         end
         next_edge();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Programmable, glitch-free clock divider with phase strobes. It replaces fixed divide-by-two and divide-by-four stages in the processor clock tree. It derives new_clk at an even ratio N of clk, and also provides single-cycle rise and fall strobes plus a 2-bit phase count that downstream pipeline control uses as clock enables. N can be changed at run time; a new N takes effect only at a full-period boundary.

Parameters:
CNT_W, 8, width of the divide ratio and the internal counter.
DEF_DIV, 4, divide ratio after reset; must be even and at least 2.

Ports:
clk  input  1  system clock
clr  input  1  asynchronous active-high reset
en  input  1  count enable; low freezes the divider
div_in  input  CNT_W  requested divide ratio
div_load  input  1  one-cycle request to load div_in
div_ack  output  1  one-cycle pulse when a pending ratio is applied
div_err  output  1  one-cycle pulse when a load is rejected
new_clk  output  1  divided clock, 50% duty
rise_tick  output  1  high for the one clk cycle in which new_clk has just gone 0->1
fall_tick  output  1  high for the one clk cycle in which new_clk has just gone 1->0
phase  output  2  counts new_clk rising edges, modulo 4
cur_div  output  CNT_W  divide ratio currently in effect

Behaviour:
- Clock and reset: one clock, clk. Reset clr is asynchronous and active-high.
- While clr is high, without waiting for a clk edge:
  - cnt=0, new_clk=0, rise_tick=0, fall_tick=0, phase=0
  - cur_div=DEF_DIV, pending cleared, div_ack=0, div_err=0
- All outputs are registered.
- Divider, on each clk edge with en=1:
  - If cnt == cur_div/2 - 1: cnt<=0, new_clk<=~new_clk.
  - Otherwise: cnt<=cnt+1.
  - Result: new_clk toggles every N/2 cycles, giving period N.
  - N=2 toggles new_clk every cycle. N=4 matches the existing divide-by-four.
- rise_tick<=1 on a 0->1 toggle; fall_tick<=1 on a 1->0 toggle; both are 0 otherwise.
- phase increments on each 0->1 toggle and wraps 3->0.
- en=0:
  - cnt, new_clk and phase hold.
  - rise_tick and fall_tick are 0.
  - Loads are still accepted. A pending ratio waits for the next enabled boundary.
- Load handling, on a clk edge with div_load=1:
  - Bit 0 of div_in is forced to 0 (odd values round down).
  - If the rounded value is < 2: div_err<=1 for one cycle; pending is unchanged.
  - Otherwise: pending<=rounded value, pending_valid<=1.
  - A load that arrives while a ratio is already pending overwrites it (last write wins). Only one div_ack is produced.
- Applying a pending ratio:
  - Applied on an enabled 1->0 toggle of new_clk, which is the period boundary.
  - On that edge: cur_div<=pending, pending_valid<=0, div_ack<=1 for one cycle.
  - The following low half-period already uses the new N/2.
  - A load on the same edge as the boundary applies the previously pending value. The new value becomes pending for the next boundary.
  - A load with no ratio pending on a boundary edge is applied at the next boundary, not the current one.
- No glitches: new_clk is only ever driven from its flop. No half-period is shorter than min(old, new)/2 cycles.
- Reset mid-operation: any pending ratio is discarded and the divider restarts from the reset values.

Test Plan:
1. Default N=4, en=1 from edge 1 -> new_clk rises after edges 2,6,10 and falls after edges 4,8. rise_tick is high for one cycle after edges 2,6,10. phase goes 1,2,3 and then wraps to 0 after edge 14.
2. Load div_in=8 during the high half (after edge 3) -> new_clk falls after edge 4, with div_ack after edge 4 and cur_div=8. The next rise is after edge 8, the next fall after edge 12.
3. Load div_in=7 -> cur_div becomes 6 at the next boundary, with div_ack. Load div_in=1 -> div_err pulse, no div_ack, cur_div unchanged, period unchanged.
4. Load 10 then 6 on consecutive cycles before a boundary -> at the boundary cur_div=6 and exactly one div_ack. Period becomes 6.
5. en=0 for 5 cycles when cnt=0 in the high half, N=4 -> new_clk stays 1, no ticks, phase holds. After en returns, the fall occurs 2 enabled edges later.
6. Assert clr between edges while a ratio is pending and new_clk=1 -> new_clk, phase and ticks go 0 immediately, cur_div=4, and the pending ratio is lost. After release, the first rise is after edge 2.
